// File: rtl/lsu.sv
// Load/store unit between the execute stage and a byte-addressed dmem with 2-cycle registered reads.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module lsu #(
  parameter int unsigned DMEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, L1, L2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic [32:0] end_addr;
  logic        f3_bad, out_of_range, misaligned, req_err, accept;
  logic [31:0] load_ext;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready && !rst;
  assign mem_addr   = (state_q == IDLE) ? req_addr : addr_q;
  assign mem_wdata  = req_wdata;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    size      = 3'd4;
    size_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   begin size = 3'd1; size_mask = 4'b0001; end
      2'b01:   begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
  end

  // 33-bit sum so addresses close to 2^32 cannot wrap back into range.
  assign end_addr     = {1'b0, req_addr} + {30'd0, size};
  assign out_of_range = end_addr > 33'(DMEM_BYTES);
  assign f3_bad       = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                               : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                                  (req_funct3 == 3'b111));
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = f3_bad || out_of_range || misaligned;
`else
  assign req_err = f3_bad || out_of_range;
`endif

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_we       = 1'b0;
    mem_wmask    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            mem_we       = 1'b1;
            mem_wmask    = size_mask;
            resp_valid_d = 1'b1;
          end else begin
            state_d = L1;
          end
        end
      end
      L1: state_d = L2;
      L2: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      funct3_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-array dmem model that has a 2-cycle registered read path.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  lsu #(.DMEM_BYTES(16384)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem model: byte array, read data registered twice after the address.
  logic [7:0]  mem [0:16383];
  logic [31:0] rd_s1, rd_s2;
  assign mem_rdata = rd_s2;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_we && mem_wmask[k]) mem[14'(mem_addr + k)] <= mem_wdata[8*k +: 8];
    rd_s1 <= {mem[14'(mem_addr + 3)], mem[14'(mem_addr + 2)],
              mem[14'(mem_addr + 1)], mem[14'(mem_addr)]};
    rd_s2 <= rd_s1;
  end

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                           output logic we, output logic [3:0] mask, output logic [31:0] maddr,
                           output logic rv, output logic err, output logic [31:0] rd);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = data;
    #1;
    we = mem_we; mask = mem_wmask; maddr = mem_addr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rv = resp_valid; err = resp_err; rd = resp_rdata;
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                          output int lat, output logic err, output logic [31:0] rd,
                          output logic any_we);
    bit done;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = 32'hA5A5A5A5;
    #1;
    any_we = mem_we;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; err = 1'b0; rd = 32'hX; done = 0;
    for (int i = 1; i <= 6 && !done; i++) begin
      any_we = any_we | mem_we;
      if (resp_valid) begin
        lat = i; err = resp_err; rd = resp_rdata; done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, need 1 0 0 0", req_ready, resp_valid, resp_err, resp_rdata);
    end
    n_tests++;
    if (mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mem: we=%b wmask=%b, need 0 0000", mem_we, mem_wmask);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_round_trip;
    logic we, rv, err, any_we; logic [3:0] mask; logic [31:0] maddr, rd; int lat;
    run_store(32'h100, 32'hDEADBEEF, F_W, we, mask, maddr, rv, err, rd);
    n_tests++;
    if (we !== 1'b1 || mask !== 4'b1111 || maddr !== 32'h100) begin
      n_fail++;
      $display("FAIL sw_port: we=%b mask=%b addr=%h, need 1 1111 00000100", we, mask, maddr);
    end
    n_tests++;
    if (rv !== 1'b1 || err !== 1'b0 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_resp: valid=%b err=%b rdata=%h, need 1 0 0", rv, err, rd);
    end
    run_load(32'h100, F_W, lat, err, rd, any_we);
    n_tests++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF || any_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_round_trip: lat=%0d err=%b rdata=%h we=%b, need 3 0 deadbeef 0", lat, err, rd, any_we);
    end
  endtask

  task automatic test_byte_extension;
    logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h100, 32'h102};
    logic [2:0]  f3s   [4] = '{F_B, F_BU, F_H, F_HU};
    logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    logic err, any_we; logic [31:0] rd; int lat;
    for (int i = 0; i < 4; i++) begin
      run_load(addrs[i], f3s[i], lat, err, rd, any_we);
      n_tests++;
      if (lat !== 3 || err !== 1'b0 || rd !== exps[i]) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: lat=%0d err=%b rdata=%h, need 3 0 %h", i, lat, err, rd, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned;
    logic we, rv, err, any_we; logic [3:0] mask; logic [31:0] maddr, rd; int lat;
    run_store(32'h201, 32'h11223344, F_W, we, mask, maddr, rv, err, rd);
    run_load(32'h201, F_W, lat, err, rd, any_we);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++;
    if (we !== 1'b0 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_sw_trap: we=%b valid=%b, need 0 1", we, rv);
    end
    n_tests++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || any_we !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_lw_trap: lat=%0d err=%b rdata=%h we=%b, need 1 1 0 0", lat, err, rd, any_we);
    end
`else
    n_tests++;
    if (we !== 1'b1 || mask !== 4'b1111 || maddr !== 32'h201 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_sw: we=%b mask=%b addr=%h valid=%b, need 1 1111 00000201 1", we, mask, maddr, rv);
    end
    n_tests++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h11223344) begin
      n_fail++;
      $display("FAIL mis_lw: lat=%0d err=%b rdata=%h, need 3 0 11223344", lat, err, rd);
    end
`endif
  endtask

  task automatic test_range_funct3;
    logic [31:0] addrs [3] = '{32'h3FFD, 32'h3FFC, 32'h40};
    logic [2:0]  f3s   [3] = '{F_W, F_W, 3'b011};
    int          lats  [3] = '{1, 3, 1};
    logic        errs  [3] = '{1'b1, 1'b0, 1'b1};
    logic we, rv, err, any_we; logic [3:0] mask; logic [31:0] maddr, rd; int lat;
    for (int i = 0; i < 3; i++) begin
      run_load(addrs[i], f3s[i], lat, err, rd, any_we);
      n_tests++;
      if (lat !== lats[i] || err !== errs[i] || (errs[i] && rd !== 32'd0)) begin
        n_fail++;
        $display("FAIL range_load[%0d]: lat=%0d err=%b rdata=%h, need %0d %b", i, lat, err, rd, lats[i], errs[i]);
      end
    end
    run_store(32'hFFFFFFFE, 32'h55555555, F_W, we, mask, maddr, rv, err, rd);
    n_tests++;
    if (we !== 1'b0 || mask !== 4'b0000 || rv !== 1'b1 || err !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_wrap: we=%b mask=%b valid=%b err=%b rdata=%h, need 0 0000 1 1 0", we, mask, rv, err, rd);
    end
    run_store(32'h300, 32'h55555555, 3'b100, we, mask, maddr, rv, err, rd);
    n_tests++;
    if (we !== 1'b0 || rv !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_bad_funct3: we=%b valid=%b err=%b, need 0 1 1", we, rv, err);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int ok_acc = 0, pulses = 0;
    logic err, any_we; logic [31:0] rd; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_B;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h400 + i; req_wdata = {24'hFFFFFF, vals[i]};
      #1;
      if (req_ready === 1'b1 && mem_we === 1'b1 && mem_wmask === 4'b0001) ok_acc++;
      if (i > 0 && resp_valid === 1'b1 && resp_err === 1'b0) pulses++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0;
    if (resp_valid === 1'b1) pulses++;
    @(posedge clk); #1;
    n_tests++;
    if (ok_acc !== 4 || pulses !== 4 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_b2b: accepted=%0d pulses=%0d trailing_valid=%b, need 4 4 0", ok_acc, pulses, resp_valid);
    end
    run_load(32'h400, F_W, lat, err, rd, any_we);
    n_tests++;
    if (lat !== 3 || rd !== 32'hD4C3B2A1) begin
      n_fail++;
      $display("FAIL sb_readback: lat=%0d rdata=%h, need 3 d4c3b2a1", lat, rd);
    end
  endtask

  task automatic test_store_after_load;
    logic we, rv, err, any_we; logic [3:0] mask; logic [31:0] maddr, rd; int lat;
    run_load(32'h100, F_W, lat, err, rd, any_we);
    // Store issued in the very cycle the load response is visible.
    n_tests++;
    if (req_ready !== 1'b1 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sal_load: ready=%b rdata=%h, need 1 deadbeef", req_ready, rd);
    end
    run_store(32'h100, 32'h12345678, F_W, we, mask, maddr, rv, err, rd);
    n_tests++;
    if (we !== 1'b1 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL sal_store: we=%b valid=%b, need 1 1", we, rv);
    end
    run_load(32'h100, F_W, lat, err, rd, any_we);
    n_tests++;
    if (rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL sal_readback: rdata=%h, need 12345678", rd);
    end
  endtask

  task automatic test_reset_in_load;
    int stray = 0;
    logic we_in_rst;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_l1: ready=%b valid=%b, need 1 0", req_ready, resp_valid);
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h500; req_wdata = 32'h77777777;
    #1;
    we_in_rst = mem_we;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (we_in_rst !== 1'b0 || stray !== 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_override: we=%b stray_pulses=%0d ready=%b, need 0 0 1", we_in_rst, stray, req_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    test_reset();
    test_word_round_trip();
    test_byte_extension();
    test_misaligned();
    test_range_funct3();
    test_back_to_back();
    test_store_after_load();
    test_reset_in_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
